// File: rtl/gcn_pkg.sv
// Shared types and constants for the COO graph aggregation engine.
// Holds the controller state encoding and the saturating-adder guard width.
package gcn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SEED,
    EDGE,
    STREAM,
    FIN
  } state_e;

  // One guard bit above the accumulator catches the carry that triggers saturation.
  localparam int SAT_CARRY_W = 1;

  localparam logic [2:0] PH_ADDR = 3'd0;
  localparam logic [2:0] PH_IDX  = 3'd1;
  localparam logic [2:0] PH_FWD  = 3'd2;
  localparam logic [2:0] PH_RIDX = 3'd3;
  localparam logic [2:0] PH_REV  = 3'd4;

endpackage

// File: rtl/sat_add_vec.sv
// NUM_CH parallel unsigned adders that clamp at 2^ACC_W-1 instead of wrapping.
module sat_add_vec #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 20
) (
  input  logic [NUM_CH-1:0][ACC_W-1:0]  acc_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0] add_i,
  output logic [NUM_CH-1:0][ACC_W-1:0]  sum_o
);
  import gcn_pkg::*;

  localparam int WIDE_W = ACC_W + SAT_CARRY_W;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDE_W-1:0] wide;
    assign wide     = WIDE_W'(acc_i[c]) + WIDE_W'(add_i[c]);
    assign sum_o[c] = (wide[WIDE_W-1:ACC_W] != '0) ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/coo_aggregate_engine.sv
// Aggregates transformed node rows along COO edges into per-node accumulators,
// then streams the accumulated rows out over a valid/ready handshake.
module coo_aggregate_engine #(
  parameter int NUM_NODES = 6,
  parameter int NUM_EDGES = 6,
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 20,
  parameter int SELF_LOOP = 1,
  parameter int SYMMETRIC = 0,
  parameter int IDX_W     = $clog2(NUM_NODES),
  parameter int EDGE_W    = $clog2(NUM_EDGES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [EDGE_W-1:0]              coo_address,
  input  logic [1:0][IDX_W-1:0]          coo_in,
  output logic [IDX_W-1:0]               row_index,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  row_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_node,
  output logic [NUM_CH-1:0][ACC_W-1:0]   out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  import gcn_pkg::*;

  localparam int CNT_W = (IDX_W > EDGE_W) ? IDX_W : EDGE_W;
  localparam logic [CNT_W-1:0] LAST_NODE = CNT_W'(NUM_NODES - 1);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(NUM_EDGES - 1);

  state_e                        state_q, state_d;
  logic [2:0]                    phase_q, phase_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              src_q, src_d, dst_q, dst_d;
  logic                          skip_q, skip_d, err_q, err_d;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q [NUM_NODES];

  logic                          acc_clr, acc_we, edge_next, edge_oob, rev_needed;
  logic [IDX_W-1:0]              acc_sel;
  logic [NUM_CH-1:0][ACC_W-1:0]  sum, seed_ext, acc_wdata;

  assign edge_oob   = (int'(coo_in[0]) >= NUM_NODES) || (int'(coo_in[1]) >= NUM_NODES);
  assign rev_needed = (SYMMETRIC != 0) && (src_q != dst_q);

  assign acc_sel = (state_q == SEED)                         ? cnt_q[IDX_W-1:0] :
                   (state_q == EDGE && phase_q == PH_REV)    ? src_q : dst_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_seed
    assign seed_ext[c] = ACC_W'(row_data[c]);
  end

  sat_add_vec #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_sat (
    .acc_i (acc_q[acc_sel]),
    .add_i (row_data),
    .sum_o (sum)
  );

  assign acc_wdata = (state_q == SEED) ? seed_ext : sum;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    skip_d      = skip_q;
    err_d       = err_q;
    acc_clr     = 1'b0;
    acc_we      = 1'b0;
    edge_next   = 1'b0;
    coo_address = '0;
    row_index   = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        err_d   = 1'b0;
        cnt_d   = '0;
        phase_d = PH_ADDR;
      end
      CLEAR: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        phase_d = PH_ADDR;
        state_d = (SELF_LOOP != 0) ? SEED : EDGE;
      end
      SEED: begin
        row_index = cnt_q[IDX_W-1:0];
        if (phase_q == PH_ADDR) begin
          phase_d = PH_IDX;
        end else begin
          acc_we  = 1'b1;
          phase_d = PH_ADDR;
          if (cnt_q == LAST_NODE) begin
            cnt_d   = '0;
            state_d = EDGE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EDGE: begin
        coo_address = cnt_q[EDGE_W-1:0];
        case (phase_q)
          PH_ADDR: phase_d = PH_IDX;
          PH_IDX: begin
            src_d   = coo_in[0];
            dst_d   = coo_in[1];
            skip_d  = edge_oob;
            phase_d = PH_FWD;
            if (edge_oob) err_d = 1'b1;
            else          row_index = coo_in[0];
          end
          PH_FWD: begin
            acc_we = !skip_q;
            // Skipped edges still spend the same cycles so run length never depends on data validity.
            if (rev_needed) phase_d   = PH_RIDX;
            else            edge_next = 1'b1;
          end
          PH_RIDX: begin
            if (!skip_q) row_index = dst_q;
            phase_d = PH_REV;
          end
          PH_REV: begin
            acc_we    = !skip_q;
            edge_next = 1'b1;
          end
          default: phase_d = PH_ADDR;
        endcase
        if (edge_next) begin
          phase_d = PH_ADDR;
          if (cnt_q == LAST_EDGE) begin
            cnt_d   = '0;
            state_d = STREAM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STREAM: if (out_ready) begin
        if (cnt_q == LAST_NODE) state_d = FIN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= PH_ADDR;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || acc_clr) begin
      for (int n = 0; n < NUM_NODES; n++) acc_q[n] <= '0;
    end else if (acc_we) begin
      acc_q[acc_sel] <= acc_wdata;
    end
  end

  assign out_valid = (state_q == STREAM);
  assign out_node  = out_valid ? cnt_q[IDX_W-1:0] : '0;
  assign out_data  = out_valid ? acc_q[out_node] : '0;
  assign busy      = (state_q == CLEAR) || (state_q == SEED) || (state_q == EDGE) || (state_q == STREAM);
  assign done      = (state_q == FIN);
  assign err       = err_q;

endmodule

// File: tb/tb_coo_aggregate_engine.sv
// Randomized bench for coo_aggregate_engine: two configurations checked against a graph-level reference model.
module tb_coo_aggregate_engine;

  localparam int N  = 6;
  localparam int E  = 6;
  localparam int CH = 3;

  logic clk = 1'b0;
  logic reset, start0, start1, out_ready;

  logic [2:0]            coo_addr0, coo_addr1, row_idx0, row_idx1;
  logic [1:0][2:0]       coo_in0, coo_in1;
  logic [CH-1:0][15:0]   row_data0, row_data1;
  logic                  out_valid0, out_valid1, busy0, busy1, done0, done1, err0, err1;
  logic [2:0]            out_node0, out_node1;
  logic [CH-1:0][19:0]   out_data0;
  logic [CH-1:0][15:0]   out_data1;

  logic [2:0]  src_tab [E];
  logic [2:0]  dst_tab [E];
  logic [15:0] row_tab [8][CH];

  longint exp_acc [N][CH];
  bit     exp_err;
  int     exp_cyc;
  int     n_checks = 0;
  int     n_fail   = 0;

  bit          sel;
  logic        o_valid, o_busy, o_done, o_err;
  logic [2:0]  o_node, o_addr, o_ridx;
  logic [59:0] o_data;

  always #5 clk = ~clk;

  coo_aggregate_engine dut0 (
    .clk(clk), .reset(reset), .start(start0), .coo_address(coo_addr0), .coo_in(coo_in0),
    .row_index(row_idx0), .row_data(row_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_node(out_node0), .out_data(out_data0), .busy(busy0), .done(done0), .err(err0)
  );

  coo_aggregate_engine #(.SELF_LOOP(0), .SYMMETRIC(1), .ACC_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .coo_address(coo_addr1), .coo_in(coo_in1),
    .row_index(row_idx1), .row_data(row_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_node(out_node1), .out_data(out_data1), .busy(busy1), .done(done1), .err(err1)
  );

  // Memories with one cycle of read latency for each engine.
  always @(posedge clk) begin
    coo_in0   <= {dst_tab[coo_addr0], src_tab[coo_addr0]};
    coo_in1   <= {dst_tab[coo_addr1], src_tab[coo_addr1]};
    row_data0 <= {row_tab[row_idx0][2], row_tab[row_idx0][1], row_tab[row_idx0][0]};
    row_data1 <= {row_tab[row_idx1][2], row_tab[row_idx1][1], row_tab[row_idx1][0]};
  end

  always_comb begin
    if (sel) begin
      o_valid = out_valid1; o_busy = busy1; o_done = done1; o_err = err1;
      o_node  = out_node1;  o_addr = coo_addr1; o_ridx = row_idx1;
      o_data  = {4'h0, out_data1[2], 4'h0, out_data1[1], 4'h0, out_data1[0]};
    end else begin
      o_valid = out_valid0; o_busy = busy0; o_done = done0; o_err = err0;
      o_node  = out_node0;  o_addr = coo_addr0; o_ridx = row_idx0;
      o_data  = out_data0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Graph-level reference: seed, apply each in-range edge (and its reverse), clamp per channel.
  task automatic model(input bit sl, input bit sym, input int accw);
    longint maxv = (64'd1 << accw) - 1;
    exp_err = 1'b0;
    exp_cyc = 1 + (sl ? 2 * N : 0) + N;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < CH; c++)
        exp_acc[n][c] = sl ? longint'(row_tab[n][c]) : 0;
    for (int e = 0; e < E; e++) begin
      int s = int'(src_tab[e]);
      int d = int'(dst_tab[e]);
      exp_cyc += (sym && s != d) ? 5 : 3;
      if (s >= N || d >= N) begin
        exp_err = 1'b1;
        continue;
      end
      for (int c = 0; c < CH; c++) begin
        exp_acc[d][c] = exp_acc[d][c] + row_tab[s][c];
        if (exp_acc[d][c] > maxv) exp_acc[d][c] = maxv;
      end
      if (sym && s != d)
        for (int c = 0; c < CH; c++) begin
          exp_acc[s][c] = exp_acc[s][c] + row_tab[d][c];
          if (exp_acc[s][c] > maxv) exp_acc[s][c] = maxv;
        end
    end
  endtask

  function automatic logic [59:0] exp_row(input int n);
    logic [59:0] r = '0;
    for (int c = 0; c < CH; c++) r[c*20 +: 20] = exp_acc[n][c][19:0];
    return r;
  endfunction

  task automatic rand_tables(input int oob_pct, input int maxv);
    for (int n = 0; n < 8; n++)
      for (int c = 0; c < CH; c++) row_tab[n][c] = 16'($urandom_range(0, maxv));
    for (int e = 0; e < E; e++) begin
      src_tab[e] = ($urandom_range(0, 99) < oob_pct) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      dst_tab[e] = ($urandom_range(0, 99) < oob_pct) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // rmode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_case(input bit s, input int rmode, input bit chk_cyc, input bit poke);
    int cycles = 0;
    int node_exp = 0;
    int p = 0;
    bit seen = 1'b0;
    logic [3:0] pat = 4'b1001;
    sel = s;
    if (s) model(1'b0, 1'b1, 16);
    else   model(1'b1, 1'b0, 20);
    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    check("busy_after_start", 64'(o_busy), 64'd1);
    check("err_cleared_by_start", 64'(o_err), 64'd0);
    for (int k = 0; k < 600; k++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      set_start(s, 1'b0);
      out_ready = 1'b1;
      if (o_valid) begin
        check("out_node", 64'(o_node), 64'(node_exp));
        check("out_data", 64'(o_data), 64'(exp_row(node_exp)));
        case (rmode)
          1:       out_ready = pat[p % 4];
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
        if (poke && p == 1) set_start(s, 1'b1);
        if (out_ready) node_exp++;
        p++;
      end
      @(negedge clk);
      cycles++;
    end
    set_start(s, 1'b0);
    check("done_seen", 64'(seen), 64'd1);
    check("nodes_emitted", 64'(node_exp), 64'(N));
    check("err_at_done", 64'(o_err), 64'(exp_err));
    check("busy_low_at_done", 64'(o_busy), 64'd0);
    if (chk_cyc) check("run_cycles", 64'(cycles), 64'(exp_cyc));
    @(negedge clk);
    check("done_one_pulse", 64'(o_done), 64'd0);
    check("idle_after_done", 64'(o_busy), 64'd0);
    check("idle_coo_address", 64'(o_addr), 64'd0);
    check("idle_row_index", 64'(o_ridx), 64'd0);
  endtask

  initial begin
    bit done_seen;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; out_ready = 1'b1; sel = 1'b0;
    rand_tables(0, 100);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #0;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      check("rst_out_valid", 64'(o_valid), 64'd0);
      check("rst_out_node", 64'(o_node), 64'd0);
      check("rst_coo_address", 64'(o_addr), 64'd0);
      check("rst_row_index", 64'(o_ridx), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Self-loop chain: rows n+1, edges 0->1 and 2->1, remaining edges out of range.
    for (int n = 0; n < 8; n++)
      for (int c = 0; c < CH; c++) row_tab[n][c] = 16'(n + 1);
    src_tab = '{3'd0, 3'd2, 3'd7, 3'd7, 3'd7, 3'd7};
    dst_tab = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    run_case(1'b0, 0, 1'b1, 1'b0);

    // Symmetric edge plus self-edge applied only once.
    for (int n = 0; n < 8; n++)
      for (int c = 0; c < CH; c++) row_tab[n][c] = 16'd0;
    for (int c = 0; c < CH; c++) begin
      row_tab[0][c] = 16'd5; row_tab[1][c] = 16'd7; row_tab[2][c] = 16'd4;
    end
    src_tab = '{3'd0, 3'd2, 3'd6, 3'd6, 3'd6, 3'd6};
    dst_tab = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd6};
    run_case(1'b1, 0, 1'b1, 1'b0);

    // Saturation with a 16-bit accumulator.
    for (int n = 0; n < 8; n++)
      for (int c = 0; c < CH; c++) row_tab[n][c] = (n < 4) ? 16'hF000 : 16'd1;
    src_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    dst_tab = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd4, 3'd5};
    run_case(1'b1, 0, 1'b1, 1'b0);

    // Out-of-range destination, then a clean run that must clear err.
    rand_tables(0, 65535);
    dst_tab[3] = 3'd7;
    run_case(1'b0, 0, 1'b1, 1'b0);
    rand_tables(0, 65535);
    run_case(1'b0, 0, 1'b1, 1'b0);

    // Stalled stream with a start poke while streaming.
    rand_tables(10, 65535);
    run_case(1'b0, 1, 1'b0, 1'b1);
    rand_tables(10, 65535);
    run_case(1'b1, 1, 1'b0, 1'b1);

    // Reset during the edge phase aborts the run without done.
    sel = 1'b0;
    rand_tables(0, 65535);
    src_tab[0] = 3'd7;
    done_seen = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_err_before_reset", 64'(o_err), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_done", 64'(o_done), 64'd0);
    check("abort_err", 64'(o_err), 64'd0);
    check("abort_out_valid", 64'(o_valid), 64'd0);
    check("abort_out_node", 64'(o_node), 64'd0);
    check("abort_coo_address", 64'(o_addr), 64'd0);
    check("abort_row_index", 64'(o_ridx), 64'd0);
    rand_tables(0, 65535);
    run_case(1'b0, 0, 1'b1, 1'b0);

    // Random runs on both configurations.
    for (int i = 0; i < 8; i++) begin
      rand_tables(15, 65535);
      run_case(1'(i % 2), 2, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coo_aggregate_engine.md
COO_AGGREGATE_ENGINE -- requirements
Module: coo_aggregate_engine

Interface
REQ-001 Parameter NUM_NODES, default 6: graph node count; also the number of accumulator rows.
REQ-002 Parameter NUM_EDGES, default 6: COO column count processed per run.
REQ-003 Parameter NUM_CH, default 3: channels per transformed row.
REQ-004 Parameter DATA_W, default 16: transformed-row element width, unsigned.
REQ-005 Parameter ACC_W, default 20: accumulator element width, unsigned, ACC_W >= DATA_W.
REQ-006 Parameter SELF_LOOP, default 1: 1 seeds acc[n] with row[n] before edges.
REQ-007 Parameter SYMMETRIC, default 0: 1 also applies the reverse edge.
REQ-008 Parameters IDX_W = $clog2(NUM_NODES) and EDGE_W = $clog2(NUM_EDGES), derived.
REQ-009 clk  in  1  single clock, rising edge.
REQ-010 reset  in  1  synchronous, active-high.
REQ-011 start  in  1  one-cycle request to begin a run.
REQ-012 coo_address  out  EDGE_W  COO column being requested.
REQ-013 coo_in  in  IDX_W x2  [0]=src, [1]=dst; valid 1 cycle after coo_address.
REQ-014 row_index  out  IDX_W  transformed-row read index.
REQ-015 row_data  in  DATA_W x NUM_CH  row contents; valid 1 cycle after row_index.
REQ-016 out_valid / out_ready  out / in  1 each  result-stream handshake.
REQ-017 out_node  out  IDX_W  node index of the current output row.
REQ-018 out_data  out  ACC_W x NUM_CH  aggregated row.
REQ-019 busy  out  1  high from accepted start to done.
REQ-020 done  out  1  one-cycle pulse at run end.
REQ-021 err  out  1  sticky flag for skipped out-of-range edges; cleared by the next accepted start.

Function
REQ-022 States SHALL be IDLE, CLEAR, SEED, EDGE, STREAM and FIN.
REQ-023 IDLE->CLEAR on start; start SHALL be ignored in every non-IDLE state.
REQ-024 CLEAR SHALL zero all accumulators in 1 cycle, then go to SEED if SELF_LOOP=1, else to EDGE.
REQ-025 SEED SHALL use 2 cycles per node n = 0..NUM_NODES-1: cycle 1 drives row_index=n; cycle 2 sets acc[n]=row_data.
REQ-026 EDGE step, forward, 3 cycles per edge e = 0..NUM_EDGES-1: drive coo_address=e; latch src/dst and drive row_index=src; acc[dst] += row_data per channel.
REQ-027 If SYMMETRIC=1 and src!=dst, each edge SHALL add 2 cycles: row_index=dst, then acc[src] += row_data; when src==dst the edge SHALL NOT be applied twice.
REQ-028 If src or dst >= NUM_NODES, the edge SHALL be skipped with no accumulator change, err SHALL be set, and the cycle count SHALL be unchanged.
REQ-029 Accumulation SHALL be unsigned and saturate at 2^ACC_W-1 per channel; it SHALL NOT wrap.
REQ-030 After the last edge, STREAM SHALL present nodes 0..NUM_NODES-1 in order; the row advances only on out_valid & out_ready.
REQ-031 While out_valid=1 and out_ready=0, out_node and out_data SHALL hold stable.
REQ-032 FIN SHALL follow the final handshake and pulse done for 1 cycle, then go to IDLE; busy falls in the same cycle as done.
REQ-033 Idle coo_address and row_index SHALL be 0.

Reset
REQ-034 Reset SHALL force IDLE, clear all accumulators, and drive busy, done, err, out_valid, out_node, coo_address and row_index to 0.
REQ-035 Reset mid-run SHALL abort the run with no done pulse; the next start SHALL begin a fresh run.

Structure
REQ-036 A shared package gcn_pkg SHALL hold the state enum and the saturating-add width constants.
REQ-037 One sub-module, sat_add_vec (NUM_CH parallel saturating adders), SHALL be used; the accumulators live in the top level.

Verification
REQ-038 SELF_LOOP=1, SYMMETRIC=0, rows r[n]=n+1 on every channel, edges (0->1),(2->1) -> acc[1]=2+1+3=6 and other acc[n]=n+1; done after 1+12+18+6 cycles with out_ready=1.
REQ-039 SYMMETRIC=1, edge (0->1) with rows 5 and 7 and SELF_LOOP=0 -> acc[1]=5, acc[0]=7; self-edge (2->2) with row 4 -> acc[2]=4 only.
REQ-040 DATA_W=16, ACC_W=16, 3 edges into node 0 each with row value 0xF000 -> acc[0]=0xFFFF on all channels.
REQ-041 Edge with dst=7 when NUM_NODES=6 -> skipped, err=1, other results unchanged; the next start clears err.
REQ-042 Stream with out_ready toggling 1,0,0,1 -> each node emitted exactly once in order, data stable while stalled; a start during STREAM is ignored.
REQ-043 Assert reset during EDGE -> outputs reach reset values the next cycle, no done; a new start completes correctly.
